cla4_bist_driver: RTL

//   On-chip stimulus/response engine for the 4-bit carry-lookahead adder.

---
 rtl/cla4_bist_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cla4_bist_driver.sv
// Self-test engine for the 4-bit carry-lookahead adder: sweeps all 512 {cin,b,a}
// vectors and checks each sum/carry. Optional build macro: CLA4_BIST_STOP_ON_FAIL_EN.
module cla4_bist_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       dut_a,
    output logic [3:0]       dut_b,
    output logic             dut_cin,
    input  logic [3:0]       dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_seen,
    output logic [8:0]       fail_vec,
    output logic [1:0]       dbg_state
);

    // start is a level request with no ready: it is acted on at any rising edge
    // where the engine sits in IDLE or FINISH, and ignored while busy is high.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [3:0]       SETTLE  = 4'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    state_t           state;
    logic [8:0]       idx;
    logic [3:0]       cnt;

    logic [4:0]       exp_sum;
    logic             mismatch;
    logic [ERR_W-1:0] err_upd;
    logic [8:0]       idx_next;
    logic             last_vec;

    always_comb begin
        exp_sum  = {1'b0, dut_a} + {1'b0, dut_b} + {4'd0, dut_cin};
        mismatch = ({dut_cout, dut_sum} != exp_sum);
        err_upd  = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_upd = err_count + ERR_ONE;
        end
        idx_next = idx + 9'd1;
        last_vec = (idx == 9'h1FF);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            dut_a     <= '0;
            dut_b     <= '0;
            dut_cin   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_seen <= 1'b0;
            fail_vec  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        idx       <= '0;
                        err_count <= '0;
                        fail_seen <= 1'b0;
                        fail_vec  <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        {dut_cin, dut_b, dut_a} <= 9'd0;
                        cnt       <= SETTLE;
                        state     <= ST_APPLY;
                    end
                end

                ST_APPLY: begin
                    if (cnt == 4'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_CHECK: begin
`ifdef CLA4_BIST_STOP_ON_FAIL_EN
                    // Counter was cleared at start, so the first mismatch lands it at 1.
                    if (mismatch) begin
                        err_count <= err_upd;
                        fail_seen <= 1'b1;
                        fail_vec  <= idx;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_FINISH;
                    end else if (last_vec) begin
                        done  <= 1'b1;
                        pass  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_FINISH;
                    end else begin
                        idx   <= idx_next;
                        {dut_cin, dut_b, dut_a} <= idx_next;
                        cnt   <= SETTLE;
                        state <= ST_APPLY;
                    end
`else
                    err_count <= err_upd;
                    if (mismatch && !fail_seen) begin
                        fail_seen <= 1'b1;
                        fail_vec  <= idx;
                    end
                    if (last_vec) begin
                        done  <= 1'b1;
                        pass  <= (err_upd == '0);
                        busy  <= 1'b0;
                        state <= ST_FINISH;
                    end else begin
                        idx   <= idx_next;
                        {dut_cin, dut_b, dut_a} <= idx_next;
                        cnt   <= SETTLE;
                        state <= ST_APPLY;
                    end
`endif
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
